// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the 5-stage pipeline. Freezes the whole
// pipeline across L1 D-cache misses (RUN / MEM_WAIT FSM), resolves load-use
// hazards and taken-branch flushes with fixed priority
// (memstall > load_use > branch > normal), keeps saturating event counters
// and a sticky miss-timeout flag.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   IFID_rs1_i/IFID_rs2_i     source registers of the instruction in ID
//   IFID_rs2_valid_i          ID instruction actually reads rs2
//   IDEX_MemRead_i/IDEX_rd_i  EX instruction is a load / its destination
//   branch_taken_i            ID-stage branch resolved taken
//   dcache_miss_i             MEM access missed the D-cache (level)
//   dcache_ack_i              refill complete (one-cycle pulse)
//   pc_write_o, stall_o, mem_stall_o, flush_o, bubble_o   pipeline controls
//   state_o                   0 = RUN, 1 = MEM_WAIT
//   load_use_cnt_o, mem_stall_cnt_o, flush_cnt_o          event counters
//   err_timeout_o             sticky miss-timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IFID_rs1_i,
   input  logic [4:0]       IFID_rs2_i,
   input  logic             IFID_rs2_valid_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_rd_i,
   input  logic             branch_taken_i,
   input  logic             dcache_miss_i,
   input  logic             dcache_ack_i,
   output logic             pc_write_o,
   output logic             stall_o,
   output logic             mem_stall_o,
   output logic             flush_o,
   output logic             bubble_o,
   output logic             state_o,
   output logic [CNT_W-1:0] load_use_cnt_o,
   output logic [CNT_W-1:0] mem_stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_timeout_o
);

   localparam logic StRun     = 1'b0;
   localparam logic StMemWait = 1'b1;

   localparam logic [7:0]       TimeoutVal = 8'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   logic             state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

   logic load_use;
   logic mem_stall;
   logic [7:0] wait_inc;

   assign load_use = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                     ((IDEX_rd_i == IFID_rs1_i) ||
                      (IFID_rs2_valid_i && (IDEX_rd_i == IFID_rs2_i)));

   assign mem_stall = (state_q == StMemWait) || dcache_miss_i;

   // Control decode, fixed priority.
   always_comb begin
      pc_write_o  = 1'b1;
      stall_o     = 1'b0;
      mem_stall_o = 1'b0;
      flush_o     = 1'b0;
      bubble_o    = 1'b0;
      if (mem_stall) begin
         mem_stall_o = 1'b1;
         pc_write_o  = 1'b0;
      end else if (load_use) begin
         stall_o    = 1'b1;
         bubble_o   = 1'b1;
         pc_write_o = 1'b0;
      end else if (branch_taken_i) begin
         flush_o = 1'b1;
      end
   end

   // Count of MEM_WAIT cycles including the current one, saturating.
   assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      unique case (state_q)
         StRun: begin
            // A miss acked in the same cycle is a single-cycle stall.
            if (dcache_miss_i && !dcache_ack_i) begin
               state_d = StMemWait;
               wait_d  = 8'd0;
            end
         end
         StMemWait: begin
            wait_d = wait_inc;
            if (wait_inc >= TimeoutVal) begin
               err_d = 1'b1;
            end
            if (dcache_ack_i) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      lu_cnt_d = lu_cnt_q;
      ms_cnt_d = ms_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (stall_o && lu_cnt_q != CntMax) begin
         lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
      if (mem_stall_o && ms_cnt_q != CntMax) begin
         ms_cnt_d = ms_cnt_q + CNT_W'(1);
      end
      if (flush_o && fl_cnt_q != CntMax) begin
         fl_cnt_d = fl_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StRun;
         wait_q   <= 8'd0;
         err_q    <= 1'b0;
         lu_cnt_q <= '0;
         ms_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         lu_cnt_q <= lu_cnt_d;
         ms_cnt_q <= ms_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign state_o         = state_q;
   assign err_timeout_o   = err_q;
   assign load_use_cnt_o  = lu_cnt_q;
   assign mem_stall_cnt_o = ms_cnt_q;
   assign flush_cnt_o     = fl_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Scoreboard bench: each driven cycle pushes the expected outputs computed by a
// small reference model; a negedge monitor pops and compares them. Directed
// constant checks cover the named scenarios. Small CNT_W/TIMEOUT make the
// saturation and timeout cases reachable quickly.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 4;
   localparam int          CMAX    = 15;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic [4:0]       IFID_rs1_i = '0;
   logic [4:0]       IFID_rs2_i = '0;
   logic             IFID_rs2_valid_i = 1'b0;
   logic             IDEX_MemRead_i = 1'b0;
   logic [4:0]       IDEX_rd_i = '0;
   logic             branch_taken_i = 1'b0;
   logic             dcache_miss_i = 1'b0;
   logic             dcache_ack_i = 1'b0;
   logic             pc_write_o, stall_o, mem_stall_o, flush_o, bubble_o, state_o;
   logic [CNT_W-1:0] load_use_cnt_o, mem_stall_cnt_o, flush_cnt_o;
   logic             err_timeout_o;

   pipeline_hazard_controller #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .IFID_rs1_i       (IFID_rs1_i),
      .IFID_rs2_i       (IFID_rs2_i),
      .IFID_rs2_valid_i (IFID_rs2_valid_i),
      .IDEX_MemRead_i   (IDEX_MemRead_i),
      .IDEX_rd_i        (IDEX_rd_i),
      .branch_taken_i   (branch_taken_i),
      .dcache_miss_i    (dcache_miss_i),
      .dcache_ack_i     (dcache_ack_i),
      .pc_write_o       (pc_write_o),
      .stall_o          (stall_o),
      .mem_stall_o      (mem_stall_o),
      .flush_o          (flush_o),
      .bubble_o         (bubble_o),
      .state_o          (state_o),
      .load_use_cnt_o   (load_use_cnt_o),
      .mem_stall_cnt_o  (mem_stall_cnt_o),
      .flush_cnt_o      (flush_cnt_o),
      .err_timeout_o    (err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic       pcw;
      logic       stall;
      logic       ms;
      logic       fl;
      logic       bub;
      logic       st;
      logic [3:0] lu_cnt;
      logic [3:0] ms_cnt;
      logic [3:0] fl_cnt;
      logic       err;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state.
   logic m_st;
   int   m_wait, m_lu, m_ms, m_fl;
   logic m_err;

   task automatic model_reset();
      m_st = 1'b0; m_wait = 0; m_err = 1'b0; m_lu = 0; m_ms = 0; m_fl = 0;
   endtask

   // Drive one cycle of inputs, push the expected outputs, advance the model.
   task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic v, input logic br,
                        input logic miss, input logic ack);
      exp_t e;
      logic lu, ms;
      int   cnt;
      @(posedge clk_i);
      #1;
      IDEX_MemRead_i = mr; IDEX_rd_i = rd; IFID_rs1_i = rs1; IFID_rs2_i = rs2;
      IFID_rs2_valid_i = v; branch_taken_i = br; dcache_miss_i = miss; dcache_ack_i = ack;
      lu = mr && (rd != 0) && ((rd == rs1) || (v && (rd == rs2)));
      ms = m_st || miss;
      e = '0;
      e.st = m_st; e.err = m_err;
      e.lu_cnt = 4'(m_lu); e.ms_cnt = 4'(m_ms); e.fl_cnt = 4'(m_fl);
      if (ms) e.ms = 1'b1;
      else if (lu) begin e.stall = 1'b1; e.bub = 1'b1; end
      else begin e.pcw = 1'b1; e.fl = br; end
      exp_q.push_back(e);
      if (e.stall && m_lu < CMAX) m_lu++;
      if (e.ms && m_ms < CMAX) m_ms++;
      if (e.fl && m_fl < CMAX) m_fl++;
      if (m_st) begin
         cnt = (m_wait < 255) ? m_wait + 1 : 255;
         if (cnt >= TIMEOUT) m_err = 1'b1;
         m_wait = cnt;
         if (ack) m_st = 1'b0;
      end else if (miss && !ack) begin
         m_st = 1'b1;
         m_wait = 0;
      end
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset mid-cycle; optionally with an ack pending on the bus.
   task automatic rst_pulse(input logic ack_pending);
      @(posedge clk_i);
      #1;
      IDEX_MemRead_i = 1'b0; IDEX_rd_i = '0; IFID_rs1_i = '0; IFID_rs2_i = '0;
      IFID_rs2_valid_i = 1'b0; branch_taken_i = 1'b0; dcache_miss_i = 1'b0;
      dcache_ack_i = ack_pending;
      #1;
      rst_i = 1'b1;
      #1;
      check_eq("rst_state", 32'(state_o), 32'd0);
      check_eq("rst_lu_cnt", 32'(load_use_cnt_o), 32'd0);
      check_eq("rst_ms_cnt", 32'(mem_stall_cnt_o), 32'd0);
      check_eq("rst_fl_cnt", 32'(flush_cnt_o), 32'd0);
      check_eq("rst_err", 32'(err_timeout_o), 32'd0);
      check_eq("rst_pc_write", 32'(pc_write_o), 32'd1);
      check_eq("rst_mem_stall", 32'(mem_stall_o), 32'd0);
      model_reset();
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   // Scoreboard monitor: compare away from the active edge.
   always @(negedge clk_i) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("pc_write", 32'(pc_write_o), 32'(e.pcw));
         check_eq("stall", 32'(stall_o), 32'(e.stall));
         check_eq("mem_stall", 32'(mem_stall_o), 32'(e.ms));
         check_eq("flush", 32'(flush_o), 32'(e.fl));
         check_eq("bubble", 32'(bubble_o), 32'(e.bub));
         check_eq("state", 32'(state_o), 32'(e.st));
         check_eq("lu_cnt", 32'(load_use_cnt_o), 32'(e.lu_cnt));
         check_eq("ms_cnt", 32'(mem_stall_cnt_o), 32'(e.ms_cnt));
         check_eq("fl_cnt", 32'(flush_cnt_o), 32'(e.fl_cnt));
         check_eq("err", 32'(err_timeout_o), 32'(e.err));
      end
   end

   initial begin
      model_reset();
      rst_pulse(1'b0);

      // 1: normal flow; a stray ack in RUN is ignored.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 5'(i), 5'(i + 1), 5'(i + 2), 1'b1, 1'b0, 1'b0, (i == 3));
         check_eq("t1_pc_write", 32'(pc_write_o), 32'd1);
      end
      check_eq("t1_state", 32'(state_o), 32'd0);

      // 2: load-use beats a taken branch; rd=0 never stalls; rs2 needs valid.
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("t2_stall", 32'(stall_o), 32'd1);
      check_eq("t2_flush", 32'(flush_o), 32'd0);
      idle();
      check_eq("t2_lu_cnt", 32'(load_use_cnt_o), 32'd1);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("t2_rd0_stall", 32'(stall_o), 32'd0);
      drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      check_eq("t2_lu_cnt2", 32'(load_use_cnt_o), 32'd2);

      // 3: miss at cycle 0, ack at cycle 4.
      rst_pulse(1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t3_state_c1", 32'(state_o), 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("t3_ms_ack", 32'(mem_stall_o), 32'd1);
      idle();
      check_eq("t3_ms_after", 32'(mem_stall_o), 32'd0);
      check_eq("t3_ms_cnt", 32'(mem_stall_cnt_o), 32'd5);
      // Miss acked in the same cycle: one-cycle stall, stays RUN.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      check_eq("t3_single_state", 32'(state_o), 32'd0);

      // 4: branch held through a miss flushes once, after release.
      rst_pulse(1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("t4_flush_stall", 32'(flush_o), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("t4_flush_rel", 32'(flush_o), 32'd1);
      idle();
      check_eq("t4_fl_cnt", 32'(flush_cnt_o), 32'd1);

      // 5: 10-cycle miss with TIMEOUT=4.
      rst_pulse(1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, (i == 9));
         if (i == 2) check_eq("t5_err_early", 32'(err_timeout_o), 32'd0);
         if (i == 7) check_eq("t5_err_wait", 32'(err_timeout_o), 32'd1);
      end
      idle();
      check_eq("t5_err_after", 32'(err_timeout_o), 32'd1);
      check_eq("t5_ms_after", 32'(mem_stall_o), 32'd0);
      check_eq("t5_state_after", 32'(state_o), 32'd0);

      // 6: saturation, then reset mid-MEM_WAIT with an ack pending.
      rst_pulse(1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t6_lu_sat", 32'(load_use_cnt_o), 32'd15);
      check_eq("t6_fl_sat", 32'(flush_cnt_o), 32'd15);
      check_eq("t6_ms_sat", 32'(mem_stall_cnt_o), 32'd15);
      check_eq("t6_state_wait", 32'(state_o), 32'd1);
      rst_pulse(1'b1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      check_eq("t6_state_post", 32'(state_o), 32'd0);
      check_eq("t6_ms_post", 32'(mem_stall_cnt_o), 32'd0);

      @(posedge clk_i);
      @(posedge clk_i);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the stall, MemStall and flush controls of the IF/ID register, the PC write enable and the ID/EX bubble insert. It holds an FSM that freezes the whole pipeline across multi-cycle L1 data-cache misses, resolves load-use hazards and taken-branch flushes with fixed priority, and keeps saturating event counters plus a miss-timeout flag.

Parameters:
CNT_W, 16, width of each performance counter
TIMEOUT, 255, MEM_WAIT cycles (counting the entry cycle) after which err_timeout_o sets; must fit in 8 bits

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
IFID_rs1_i  input  5  source register 1 of the instruction in ID
IFID_rs2_i  input  5  source register 2 of the instruction in ID
IFID_rs2_valid_i  input  1  instruction in ID reads rs2
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_rd_i  input  5  destination register of the instruction in EX
branch_taken_i  input  1  ID-stage branch resolved taken
dcache_miss_i  input  1  MEM-stage access missed the L1 D-cache (level)
dcache_ack_i  input  1  refill complete, one-cycle pulse
pc_write_o  output  1  PC register write enable
stall_o  output  1  to IF/ID stall_i
mem_stall_o  output  1  to IF/ID MemStall_i and all other pipeline registers
flush_o  output  1  to IF/ID flush_i (loads NOP 0x00000013)
bubble_o  output  1  ID/EX inserts NOP control
state_o  output  1  0=RUN, 1=MEM_WAIT
load_use_cnt_o  output  CNT_W  load-use stall events
mem_stall_cnt_o  output  CNT_W  cycles with mem_stall_o=1
flush_cnt_o  output  CNT_W  flush events
err_timeout_o  output  1  sticky miss-timeout flag

Behaviour:
- Reset (asynchronous): state RUN, all counters 0, wait counter 0, err_timeout_o 0. Control outputs are combinational and take the RUN decode during reset.
- load_use = IDEX_MemRead_i and IDEX_rd_i != 0 and (IDEX_rd_i == IFID_rs1_i or (IFID_rs2_valid_i and IDEX_rd_i == IFID_rs2_i)).
- memstall = (state == MEM_WAIT) or (state == RUN and dcache_miss_i).
- Priority: memstall > load_use > branch_taken_i > normal.
- memstall: mem_stall_o=1, pc_write_o=0, stall_o=0, bubble_o=0, flush_o=0. Load-use and branch are ignored. They re-evaluate after release, because the frozen ID instruction keeps presenting them.
- load_use (no memstall): stall_o=1, pc_write_o=0, bubble_o=1, flush_o=0. Lasts exactly one cycle because the load advances to MEM. A simultaneous taken branch is suppressed that cycle.
- branch_taken_i only: flush_o=1, pc_write_o=1, stall_o=0, bubble_o=0.
- Normal: pc_write_o=1, all others 0.
- FSM transitions:
  - RUN -> MEM_WAIT when dcache_miss_i=1 and dcache_ack_i=0.
  - RUN stays RUN when miss and ack are both 1 (single-cycle stall).
  - MEM_WAIT -> RUN on dcache_ack_i=1. mem_stall_o is still 1 in the ack cycle and drops in the following cycle.
  - dcache_ack_i in RUN without a miss is ignored.
- Wait counter (8-bit):
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle and saturates at 255.
  - err_timeout_o sets when the count reaches TIMEOUT in MEM_WAIT. It clears only on reset; the FSM keeps waiting.
- Performance counters (registered, saturate at all-ones, never wrap):
  - load_use_cnt_o: +1 per cycle where load_use is acted on.
  - flush_cnt_o: +1 per cycle with flush_o=1.
  - mem_stall_cnt_o: +1 per cycle with mem_stall_o=1.
- Reset mid-MEM_WAIT returns the FSM to RUN immediately; a pending ack is discarded.

Test Plan:
1. Normal flow, no hazards, 10 cycles -> pc_write_o=1 every cycle, other controls 0, counters stay 0.
2. IDEX_MemRead_i=1, IDEX_rd_i=5, IFID_rs1_i=5, branch_taken_i=1 in the same cycle -> stall_o=1, bubble_o=1, pc_write_o=0, flush_o=0 for exactly that cycle; load_use_cnt_o=1. Repeat with rd=0 -> no stall.
3. Miss at cycle 0, dcache_ack_i at cycle 4 -> mem_stall_o=1 for cycles 0-4, 0 at cycle 5; state_o=1 for cycles 1-4; mem_stall_cnt_o=5.
4. branch_taken_i held during a 3-cycle miss -> flush_o=0 throughout the stall, flush_o=1 in the first cycle after release; flush_cnt_o=1.
5. TIMEOUT=4 with a 10-cycle miss -> err_timeout_o rises while still waiting and stays 1 after ack; mem_stall_o follows the ack.
6. rst_i pulsed mid-MEM_WAIT and counters preloaded near saturation -> state_o=0 at once and counters reset to 0; separately, driving events at all-ones -> counters hold all-ones.
